sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 27 ++
 rtl/sram_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Widths, FSM state encoding and default strobe timing shared
//               by the asynchronous-SRAM controller and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 4;
    localparam int WR_CYC_DEF = 2;
    localparam int RD_CYC_DEF = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_SETUP = 3'd1;
    localparam logic [2:0] ST_WR_PULSE = 3'd2;
    localparam logic [2:0] ST_WR_HOLD  = 3'd3;
    localparam logic [2:0] ST_RD_SETUP = 3'd4;
    localparam logic [2:0] ST_RD_WAIT  = 3'd5;
    localparam logic [2:0] ST_TURN     = 3'd6;

endpackage
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Single-port asynchronous SRAM controller with one-deep write
//               and read request buffers and a write-priority strobe FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WR_CYC = WR_CYC_DEF,
    parameter int RD_CYC = RD_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sram_wreq,
    input  logic [ADDR_W-1:0] sram_waddr,
    input  logic [DATA_W-1:0] sram_wdata,
    input  logic              sram_rreq,
    input  logic [ADDR_W-1:0] sram_raddr,
    output logic [DATA_W-1:0] sram_rdata,
    output logic              sram_rvalid,
    output logic              sram_busy,
    output logic              sram_err,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_cs_n,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wpend_q, wpend_d, rpend_q, rpend_d;
    logic [ADDR_W-1:0] wa_q, wa_d, ra_q, ra_d, addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d, dout_q, dout_d, rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d, err_q, err_d;
    logic              take_wr, take_rd;
    logic              drive_bus;

    // Sequencer; the active address/data are copied out of the pending
    // registers so a new request may refill them mid-transaction.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        take_wr  = 1'b0;
        take_rd  = 1'b0;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (wpend_q)      take_wr = 1'b1;
                else if (rpend_q) take_rd = 1'b1;
                else              state_d = ST_IDLE;
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                cnt_d   = WR_LOAD;
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) state_d = ST_WR_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WR_HOLD:  state_d = ST_TURN;
            ST_RD_SETUP: begin
                state_d = ST_RD_WAIT;
                cnt_d   = RD_LOAD;
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = ST_TURN;
                    rdata_d  = sram_data;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take_wr) begin
            state_d = ST_WR_SETUP;
            addr_d  = wa_q;
            dout_d  = wd_q;
        end
        if (take_rd) begin
            state_d = ST_RD_SETUP;
            addr_d  = ra_q;
        end
    end

    // A request landing on the edge that frees its slot is accepted.
    always_comb begin
        wpend_d = wpend_q & ~take_wr;
        rpend_d = rpend_q & ~take_rd;
        wa_d    = wa_q;
        wd_d    = wd_q;
        ra_d    = ra_q;
        err_d   = err_q;
        if (sram_wreq) begin
            if (wpend_d) begin
                err_d = 1'b1;
            end else begin
                wpend_d = 1'b1;
                wa_d    = sram_waddr;
                wd_d    = sram_wdata;
            end
        end
        if (sram_rreq) begin
            if (rpend_d) begin
                err_d = 1'b1;
            end else begin
                rpend_d = 1'b1;
                ra_d    = sram_raddr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wpend_q  <= 1'b0;
            rpend_q  <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            ra_q     <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wpend_q  <= wpend_d;
            rpend_q  <= rpend_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            ra_q     <= ra_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Strobes decode straight from the state flops so reset forces them high at once.
    assign drive_bus   = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) ||
                         (state_q == ST_WR_HOLD);
    assign sram_cs_n   = (state_q == ST_IDLE) || (state_q == ST_TURN);
    assign sram_we_n   = (state_q != ST_WR_PULSE);
    assign sram_oe_n   = !((state_q == ST_RD_SETUP) || (state_q == ST_RD_WAIT));
    assign sram_data   = drive_bus ? dout_q : {DATA_W{1'bz}};
    assign sram_addr   = addr_q;
    assign sram_rdata  = rdata_q;
    assign sram_rvalid = rvalid_q;
    assign sram_err    = err_q;
    assign sram_busy   = (state_q != ST_IDLE) || wpend_q || rpend_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Scoreboard bench driving a default-timing and a
//               WR_CYC=1/RD_CYC=5 controller, each with its own SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;
    import sram_pkg::*;

    typedef struct packed {
        int         dut;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;

    logic        wreq   [2];
    logic        rreq   [2];
    logic [14:0] waddr  [2];
    logic [7:0]  wdata  [2];
    logic [14:0] raddr  [2];
    logic [7:0]  rdata  [2];
    logic        rvalid [2];
    logic        busy   [2];
    logic        err    [2];
    logic [14:0] addr   [2];
    logic        cs_n   [2];
    logic        we_n   [2];
    logic        oe_n   [2];
    wire  [7:0]  bus0;
    wire  [7:0]  bus1;

    logic [7:0]  mem0 [0:32767];
    logic [7:0]  mem1 [0:32767];

    exp_t        sb_q [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          we_run [2];
    int          we_last [2];
    int          viol_both = 0;
    int          viol_bus = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl dut0 (
        .clk(clk), .rst(rst),
        .sram_wreq(wreq[0]), .sram_waddr(waddr[0]), .sram_wdata(wdata[0]),
        .sram_rreq(rreq[0]), .sram_raddr(raddr[0]),
        .sram_rdata(rdata[0]), .sram_rvalid(rvalid[0]), .sram_busy(busy[0]),
        .sram_err(err[0]), .sram_addr(addr[0]), .sram_data(bus0),
        .sram_cs_n(cs_n[0]), .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0])
    );

    sram_ctrl #(.WR_CYC(1), .RD_CYC(5)) dut1 (
        .clk(clk), .rst(rst),
        .sram_wreq(wreq[1]), .sram_waddr(waddr[1]), .sram_wdata(wdata[1]),
        .sram_rreq(rreq[1]), .sram_raddr(raddr[1]),
        .sram_rdata(rdata[1]), .sram_rvalid(rvalid[1]), .sram_busy(busy[1]),
        .sram_err(err[1]), .sram_addr(addr[1]), .sram_data(bus1),
        .sram_cs_n(cs_n[1]), .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1])
    );

    // Released bus floats to 0xFF so any stray controller drive is visible.
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (bus0[i]);
        pullup (bus1[i]);
    end

    assign bus0 = (!cs_n[0] && !oe_n[0]) ? mem0[addr[0]] : 8'hzz;
    assign bus1 = (!cs_n[1] && !oe_n[1]) ? mem1[addr[1]] : 8'hzz;

    always @(posedge clk) begin
        if (!cs_n[0] && !we_n[0]) mem0[addr[0]] <= bus0;
        if (!cs_n[1] && !we_n[1]) mem1[addr[1]] <= bus1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic monitor();
        exp_t       e;
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                b = (d == 0) ? bus0 : bus1;
                if (!we_n[d] && !oe_n[d]) viol_both++;
                if (cs_n[d] && b !== 8'hFF) viol_bus++;
                if (!we_n[d]) begin
                    we_run[d]++;
                end else if (we_run[d] != 0) begin
                    we_last[d] = we_run[d];
                    we_run[d]  = 0;
                end
                if (rvalid[d]) begin
                    check($sformatf("rvalid_expected_dut%0d", d), sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("rvalid_dut_id", d, e.dut);
                        check($sformatf("rdata_dut%0d", d), rdata[d], e.data);
                        check($sformatf("rvalid_cycle_dut%0d", d), cyc, e.due);
                    end
                end
            end
        end
    endtask

    // One-cycle request pulse; a read pushes its expected data and the cycle
    // in which rvalid must appear (lat cycles after the sampling edge).
    task automatic issue(input int d, input bit w, input bit r,
                         input logic [14:0] wa, input logic [7:0] wd,
                         input logic [14:0] ra, input logic [7:0] exp_rd, input int lat);
        exp_t e;
        @(negedge clk);
        wreq[d]  = w;
        rreq[d]  = r;
        waddr[d] = wa;
        wdata[d] = wd;
        raddr[d] = ra;
        if (r) begin
            e.dut  = d;
            e.data = exp_rd;
            e.due  = cyc + 1 + lat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        wreq[d] = 1'b0;
        rreq[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_reached_dut%0d", d), busy[d], 0);
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            wreq[d] = 1'b0; rreq[d] = 1'b0; waddr[d] = '0; wdata[d] = '0; raddr[d] = '0;
            we_run[d] = 0; we_last[d] = 0;
        end
        fork
            monitor();
        join_none

        #12;
        check("rst_cs_n",   cs_n[0], 1);
        check("rst_we_n",   we_n[0], 1);
        check("rst_oe_n",   oe_n[0], 1);
        check("rst_addr",   addr[0], 0);
        check("rst_rdata",  rdata[0], 0);
        check("rst_rvalid", rvalid[0], 0);
        check("rst_err",    err[0], 0);
        check("rst_busy",   busy[0], 0);
        check("rst_bus",    bus0, 8'hFF);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Write then read back at default timing.
        issue(0, 1, 0, 15'h0010, 8'hA5, 15'h0, 8'h00, 0);
        wait_idle(0);
        check("we_width_default", we_last[0], 2);
        issue(0, 0, 1, 15'h0, 8'h00, 15'h0010, 8'hA5, 4);
        wait_idle(0);
        check("rdata_held", rdata[0], 8'hA5);

        // Simultaneous write and read of one address: write wins.
        issue(0, 1, 1, 15'h0020, 8'h3C, 15'h0020, 8'h3C, 9);
        wait_idle(0);
        check("err_after_simul", err[0], 0);

        // Overflow: second write while the first is still pending.
        issue(0, 1, 0, 15'h0040, 8'h11, 15'h0, 8'h00, 0);
        wait_idle(0);
        issue(0, 0, 1, 15'h0, 8'h00, 15'h0040, 8'h11, 4);
        issue(0, 1, 0, 15'h0050, 8'h77, 15'h0, 8'h00, 0);
        issue(0, 1, 0, 15'h0050, 8'h99, 15'h0, 8'h00, 0);
        wait_idle(0);
        check("err_overflow", err[0], 1);
        check("mem_first_only", mem0[15'h0050], 8'h77);
        issue(0, 0, 1, 15'h0, 8'h00, 15'h0050, 8'h77, 4);
        wait_idle(0);

        // Reset in the middle of the write strobe.
        issue(0, 1, 0, 15'h0060, 8'hEE, 15'h0, 8'h00, 0);
        repeat (2) @(negedge clk);
        check("in_wr_pulse", we_n[0], 0);
        rst = 1'b0;
        #1;
        check("abort_we_n",  we_n[0], 1);
        check("abort_cs_n",  cs_n[0], 1);
        check("abort_oe_n",  oe_n[0], 1);
        check("abort_bus",   bus0, 8'hFF);
        check("abort_busy",  busy[0], 0);
        check("abort_err",   err[0], 0);
        check("abort_rdata", rdata[0], 0);
        check("abort_addr",  addr[0], 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", busy[0], 0);
        check("post_rst_cs_n", cs_n[0], 1);

        // Fast write / slow read instance at both address extremes.
        issue(1, 1, 0, 15'h0000, 8'h5C, 15'h0, 8'h00, 0);
        wait_idle(1);
        check("we_width_fast", we_last[1], 1);
        issue(1, 1, 0, 15'h7FFF, 8'hC3, 15'h0, 8'h00, 0);
        wait_idle(1);
        check("mem_top_addr", mem1[15'h7FFF], 8'hC3);
        issue(1, 0, 1, 15'h0, 8'h00, 15'h0000, 8'h5C, 7);
        wait_idle(1);
        issue(1, 0, 1, 15'h0, 8'h00, 15'h7FFF, 8'hC3, 7);
        wait_idle(1);
        check("addr_pins_top", addr[1], 15'h7FFF);
        check("err_fast", err[1], 0);

        repeat (3) @(negedge clk);
        check("we_oe_overlap", viol_both, 0);
        check("bus_driven_outside_write", viol_bus, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
